// File: rtl/aes_inv_key_gen.sv
// aes_inv_key_gen: on-the-fly inverse AES-128 key schedule.
// After init, the forward expansion runs internally to reach round key 10,
// which is kept in last_key_q. Each next request then derives the previous
// round key from the current one. The S-box is external and shared.
module aes_inv_key_gen (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] key,
    input  logic         init,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FWD   = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [127:0] key_q, key_d;
    logic [127:0] last_key_q, last_key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   ctr_q, ctr_d;
    logic [1:0]   state_q, state_d;
    logic         ready_q, ready_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rcon_word;
    logic [31:0]  t_word;
    logic [127:0] fwd_key;
    logic [127:0] inv_key;
    logic [31:0]  p0, p1, p2, p3;
    logic [7:0]   rcon_fwd;
    logic [7:0]   rcon_inv;

    assign round_key = key_q;
    assign round     = round_q;
    assign ready     = ready_q;

    // Round datapaths: one forward step, one inverse step, and the S-box word.
    // In READY the S-box sees RotWord(w3^w2), which is w3 of the previous key.
    always_comb begin
        w0        = key_q[127:96];
        w1        = key_q[95:64];
        w2        = key_q[63:32];
        w3        = key_q[31:0];
        rcon_word = {rcon_q, 24'h0};

        t_word  = new_sboxw ^ rcon_word;
        fwd_key[127:96] = w0 ^ t_word;
        fwd_key[95:64]  = w0 ^ t_word ^ w1;
        fwd_key[63:32]  = w0 ^ t_word ^ w1 ^ w2;
        fwd_key[31:0]   = w0 ^ t_word ^ w1 ^ w2 ^ w3;

        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        p0 = w0 ^ new_sboxw ^ rcon_word;
        inv_key = {p0, p1, p2, p3};

        // xtime and its inverse over GF(2^8) with the AES polynomial.
        rcon_fwd = {rcon_q[6:0], 1'b0} ^ (8'h1b & {8{rcon_q[7]}});
        rcon_inv = rcon_q[0] ? ({1'b1, rcon_q[7:1]} ^ 8'h0d) : {1'b0, rcon_q[7:1]};

        case (state_q)
            FWD:     sboxw = {w3[23:0], w3[31:24]};
            READY:   sboxw = {p3[23:0], p3[31:24]};
            default: sboxw = 32'h0;
        endcase
    end

    // Control: init restarts expansion from any state and beats next.
    always_comb begin
        key_d      = key_q;
        last_key_d = last_key_q;
        round_d    = round_q;
        rcon_d     = rcon_q;
        ctr_d      = ctr_q;
        state_d    = state_q;
        ready_d    = ready_q;

        if (init) begin
            key_d   = key;
            rcon_d  = 8'h01;
            ctr_d   = 4'd0;
            ready_d = 1'b0;
            state_d = FWD;
        end else begin
            case (state_q)
                FWD: begin
                    key_d  = fwd_key;
                    ctr_d  = ctr_q + 4'd1;
                    rcon_d = rcon_fwd;
                    if (ctr_q == 4'd9) begin
                        last_key_d = fwd_key;
                        round_d    = 4'd10;
                        rcon_d     = 8'h36;
                        ready_d    = 1'b1;
                        state_d    = READY;
                    end
                end
                READY: begin
                    if (next) begin
                        if (round_q != 4'd0) begin
                            key_d   = inv_key;
                            round_d = round_q - 4'd1;
                            rcon_d  = rcon_inv;
                        end else begin
                            // Rewind to round key 10 for the next block.
                            key_d   = last_key_q;
                            round_d = 4'd10;
                            rcon_d  = 8'h36;
                        end
                    end
                end
                IDLE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q      <= 128'h0;
            last_key_q <= 128'h0;
            round_q    <= 4'd0;
            rcon_q     <= 8'h0;
            ctr_q      <= 4'd0;
            state_q    <= IDLE;
            ready_q    <= 1'b0;
        end else begin
            key_q      <= key_d;
            last_key_q <= last_key_d;
            round_q    <= round_d;
            rcon_q     <= rcon_d;
            ctr_q      <= ctr_d;
            state_q    <= state_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Directed bench for aes_inv_key_gen with a behavioural AES S-box.
module tb_aes_inv_key_gen;

    logic         clk;
    logic         reset_n;
    logic [127:0] key;
    logic         init;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    int checks;
    int fails;

    logic [7:0]   sbox_tbl [256];
    logic [127:0] ka [11];

    aes_inv_key_gen dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key       (key),
        .init      (init),
        .next      (next),
        .round_key (round_key),
        .round     (round),
        .ready     (ready),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External S-box: combinational SubWord.
    always_comb begin
        new_sboxw = {sbox_tbl[sboxw[31:24]], sbox_tbl[sboxw[23:16]],
                     sbox_tbl[sboxw[15:8]],  sbox_tbl[sboxw[7:0]]};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sbox_tbl = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

        // FIPS-197 A.1 round keys 0..10.
        ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
        ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        checks  = 0;
        fails   = 0;
        reset_n = 1'b0;
        key     = 128'h0;
        init    = 1'b0;
        next    = 1'b0;

        // Reset state
        #12;
        chk("rst_round_key", round_key, 128'h0);
        chk("rst_round", {124'h0, round}, 128'd0);
        chk("rst_ready", {127'h0, ready}, 128'd0);
        chk("rst_sboxw", {96'h0, sboxw}, 128'h0);
        step();
        reset_n = 1'b1;
        step();

        // next in IDLE is ignored
        next = 1'b1;
        step();
        next = 1'b0;
        chk("idle_next_round", {124'h0, round}, 128'd0);
        chk("idle_next_ready", {127'h0, ready}, 128'd0);

        // A.1 init: E0 samples init, steps at E1..E10
        key  = ka[0];
        init = 1'b1;
        step();
        init = 1'b0;
        key  = 128'hffffffffffffffffffffffffffffffff;  // must not matter
        chk("fwd_sboxw_first", {96'h0, sboxw}, {96'h0, 32'hcf4f3c09});
        chk("fwd_ready_e0", {127'h0, ready}, 128'd0);
        for (int i = 0; i < 9; i++) step();
        chk("fwd_ready_e9", {127'h0, ready}, 128'd0);
        step();
        chk("a1_ready", {127'h0, ready}, 128'd1);
        chk("a1_round10", {124'h0, round}, 128'd10);
        chk("a1_k10", round_key, ka[10]);
        chk("a1_sboxw_ready", {96'h0, sboxw}, {96'h0, 32'h5c006e57});

        // Inverse walk K10 -> K0, back-to-back
        next = 1'b1;
        for (int r = 9; r >= 0; r--) begin
            step();
            chk($sformatf("walk_round%0d", r), {124'h0, round}, 128'(r));
            chk($sformatf("walk_key%0d", r), round_key, ka[r]);
            chk($sformatf("walk_ready%0d", r), {127'h0, ready}, 128'd1);
        end
        // Wrap from round 0
        step();
        next = 1'b0;
        chk("wrap_round", {124'h0, round}, 128'd10);
        chk("wrap_key", round_key, ka[10]);
        next = 1'b1;
        step();
        next = 1'b0;
        chk("wrap_step_key", round_key, ka[9]);

        // Async reset mid-FWD
        key  = ka[0];
        init = 1'b1;
        step();
        init = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", {127'h0, ready}, 128'd0);
        chk("arst_round", {124'h0, round}, 128'd0);
        chk("arst_key", round_key, 128'h0);
        step();
        reset_n = 1'b1;

        // Restart at FWD cycle 5 with C.1 key; next during FWD ignored
        key  = ka[0];
        init = 1'b1;
        step();
        init = 1'b0;
        for (int i = 0; i < 4; i++) step();
        key  = 128'h000102030405060708090a0b0c0d0e0f;
        init = 1'b1;
        step();
        init = 1'b0;
        next = 1'b1;
        step();
        next = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("c1_ready_e9", {127'h0, ready}, 128'd0);
        step();
        chk("c1_ready", {127'h0, ready}, 128'd1);
        chk("c1_round", {124'h0, round}, 128'd10);
        chk("c1_k10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // init + next together in READY: init only
        next = 1'b1;
        step();
        chk("pre_sim_round", {124'h0, round}, 128'd9);
        key  = ka[0];
        init = 1'b1;
        step();
        init = 1'b0;
        next = 1'b0;
        chk("sim_ready", {127'h0, ready}, 128'd0);
        chk("sim_round", {124'h0, round}, 128'd9);
        for (int i = 0; i < 10; i++) step();
        chk("sim_k10", round_key, ka[10]);
        chk("sim_ready_done", {127'h0, ready}, 128'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_gen.md
# aes_inv_key_gen

On-the-fly inverse key schedule for the AES decipher datapath, AES-128 only. After `init`, the block runs the forward expansion internally without storing the intermediate round keys, and keeps only round key 10. It then walks the schedule backwards, producing round key 10, 9, …, 0 on `round_key`, one key per `next` request. This removes the 11×128-bit key memory from the decrypt-only configuration. Like the key memory, it shares one external S-box through the `sboxw`/`new_sboxw` port pair.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `key` in 128: cipher key, word w0 in [127:96]; sampled only on the `init` edge.
- `init` in 1: start the forward expansion; single-cycle pulse.
- `next` in 1: step to the previous round key; single-cycle pulse.
- `round_key` out 128: current round key, equal to `key_reg`; valid only while `ready`=1.
- `round` out 4: index of the key currently on `round_key`, 10 down to 0.
- `ready` out 1: high when `round_key`/`round` are valid and the block accepts `next`.
- `sboxw` out 32: word sent to the shared S-box.
- `new_sboxw` in 32: SubWord(`sboxw`), returned combinationally in the same cycle.

## Operation
- Registers:
  - `key_reg`[127:0]: current key, words w0..w3.
  - `last_key`[127:0]: saved round key 10.
  - `round_reg`[3:0].
  - `rcon_reg`[7:0].
  - `ctr`[3:0].
  - `state`: one of IDLE, FWD, READY.
  - `ready_reg`.
- Reset values: all registers 0, `state`=IDLE. Output consequences: `round_key`=0, `round`=0, `ready`=0, `sboxw`=0.
- `sboxw`:
  - FWD: RotWord(w3) = {w3[23:0], w3[31:24]}.
  - READY: RotWord(w3^w2).
  - IDLE: 0.
- Forward step, with t = `new_sboxw` ^ {`rcon_reg`, 24'h0}:
  - k0 = w0^t; k1 = k0^w1; k2 = k1^w2; k3 = k2^w3.
  - Rcon update: `rcon_reg` ← xtime(`rcon_reg`) = {r[6:0],0} ^ (8'h1b & {8{r[7]}}).
- Inverse step:
  - p3 = w3^w2; p2 = w2^w1; p1 = w1^w0.
  - p0 = w0 ^ `new_sboxw` ^ {`rcon_reg`, 24'h0}, with `sboxw` = RotWord(p3).
  - Rcon update: `rcon_reg` ← inv_xtime(r) = r[0] ? ({1'b1, (r^8'h1b)[7:1]}) : {1'b0, r[7:1]}.
  - Sequence of `rcon_reg` used: 36, 1b, 80, 40, …, 01.
- State transitions:
  - **IDLE/READY, `init`=1:** `key_reg`←`key`, `rcon_reg`←8'h01, `ctr`←0, `ready`←0, state←FWD.
  - **FWD:** each cycle `key_reg`←forward step, `ctr`←`ctr`+1. When `ctr`==9, the step that writes K10 also does:
    - `last_key`←K10, `round_reg`←10, `rcon_reg`←8'h36, `ready`←1, state←READY.
  - **READY, `next`=1, `round`>0:** `key_reg`←inverse step, `round_reg`←`round_reg`-1, `rcon_reg`←inv_xtime(`rcon_reg`).
  - **READY, `next`=1, `round`==0 (wrap):** `key_reg`←`last_key`, `round_reg`←10, `rcon_reg`←8'h36. The schedule rewinds for the next block without re-expanding.
- Priority and boundaries:
  - `init` has priority over `next`.
  - `init` during FWD restarts the expansion from the new `key`; the partial expansion is discarded.
  - `next` in IDLE or FWD is ignored, with no state change.
  - `init` and `next` high in the same READY cycle: treated as `init` only.
  - `key` changing outside the `init` edge has no effect.

## Timing
- Init latency: `init` is sampled at edge E0; forward steps occur at E1..E10; `ready`=1 and `round`=10 after E10. That is 11 edges counting E0.
- Step latency: `next` sampled at edge E gives the new `round_key`/`round` after E (1 cycle); `ready` stays 1.
- Back-to-back: `next` may be high on consecutive cycles, one step per cycle; 10 cycles take the key from K10 to K0.
- S-box path: `new_sboxw` is combinational from `sboxw` within the same cycle. The timing path is `key_reg` → S-box → `key_reg`, one S-box deep.
- Asynchronous reset mid-FWD or mid-READY: all registers return to reset values immediately; `ready` drops without waiting for a clock.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-FWD → `ready`=0, `round`=0, `round_key`=0 immediately; the next `init` works normally.
- **FIPS-197 A.1 init:** `init` with `key`=2b7e151628aed2a6abf7158809cf4f3c → `ready` high after 11 edges; `round`=10; `round_key`=d014f9a8c9ee2589e13f0cc8b6630ca6.
- **First inverse step:** one `next` → `round`=9, `round_key`=ac7766f319fadc2128d12941575c006e.
- **Full walk:** 9 further back-to-back `next` pulses → `round`=1 shows a0fafe1788542cb123a339392a6c7605; `round`=0 shows 2b7e151628aed2a6abf7158809cf4f3c. A `next` at `round` 0 → `round`=10, `round_key`=d014f9a8….
- **Restart and ignored next:**
  - `init` pulsed at FWD cycle 5 with `key`=000102030405060708090a0b0c0d0e0f → `ready` exactly 11 edges after the second `init`; `round_key`=13111d7fe3944a17f307a78b4d2b30c5.
  - `next` during FWD → ignored.
- **Simultaneous events:** `init` and `next` together while READY → expansion restarts, `ready`=0 on the next cycle, `round` not decremented.
